// File: rtl/three_eight_decoder_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// three_eight_decoder_sequencer_pkg : shared widths, FSM states, idle level
// Optional macro DECODER_ACTIVE_LOW_EN selects active-low y.   Rev 1.0
// ---------------------------------------------------------------------------
package three_eight_decoder_sequencer_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] Y_IDLE = 8'hFF;
`else
    localparam logic [OUT_W-1:0] Y_IDLE = 8'h00;
`endif

endpackage
`default_nettype wire

// File: rtl/three_eight_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// three_eight_decoder : combinational 3-to-8 one-hot decoder with enable
// Output polarity follows DECODER_ACTIVE_LOW_EN.                 Rev 1.0
// ---------------------------------------------------------------------------
module three_eight_decoder
    import three_eight_decoder_sequencer_pkg::*;
(
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  y
);

    logic [OUT_W-1:0] w_hot;

    for (genvar i = 0; i < OUT_W; i++) begin : g_line
        assign w_hot[i] = en && (code == CODE_W'(i));
    end

    // Disabled decoder yields all-zero hot vector, which maps onto Y_IDLE.
`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~w_hot;
`else
    assign y = w_hot;
`endif

endmodule
`default_nettype wire

// File: rtl/three_eight_decoder_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// three_eight_decoder_sequencer : handshake-fed one-hot strobe with pulse/gap
// Optional macro DECODER_ACTIVE_LOW_EN selects active-low y.   Rev 1.0
// ---------------------------------------------------------------------------
module three_eight_decoder_sequencer
    import three_eight_decoder_sequencer_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code,
    output logic [OUT_W-1:0]  y,
    output logic              y_valid,
    output logic              done
);

    if (PULSE_LEN < 1 || PULSE_LEN > 255 || GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_params
        $error("three_eight_decoder_sequencer: PULSE_LEN must be 1..255, GAP_LEN 0..255");
    end

    localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(GAP_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               done_q, done_d;

    logic               w_accept;
    logic               w_dec_en;
    logic [CODE_W-1:0]  w_dec_code;
    logic [OUT_W-1:0]   w_dec_y;

    assign in_ready = en && (state_q == IDLE) && rst_n;
    assign w_accept = in_valid && in_ready;

    // Live input code is decoded on accept; the captured code keeps y stable afterwards.
    assign w_dec_code = (state_q == IDLE) ? code : code_q;
    assign w_dec_en   = w_accept || (en && (state_q == PULSE) && (cnt_q != '0));

    three_eight_decoder u_decoder (
        .en   (w_dec_en),
        .code (w_dec_code),
        .y    (w_dec_y)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        done_d    = 1'b0;

        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            code_d    = '0;
            y_d       = Y_IDLE;
            y_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        state_d   = PULSE;
                        cnt_d     = C_PULSE_LOAD;
                        code_d    = code;
                        y_d       = w_dec_y;
                        y_valid_d = 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        y_d   = w_dec_y;
                    end else begin
                        y_d       = Y_IDLE;
                        y_valid_d = 1'b0;
                        done_d    = 1'b1;
                        if (GAP_LEN > 0) begin
                            state_d = GAP;
                            cnt_d   = C_GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    y_d       = Y_IDLE;
                    y_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            y_q       <= Y_IDLE;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            done_q    <= done_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_three_eight_decoder_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_three_eight_decoder_sequencer : two configurations (4/1 and 1/0) against
// a cycle-count reference model plus directed literal checks.     Rev 1.0
// ---------------------------------------------------------------------------
module tb_three_eight_decoder_sequencer;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam bit         ACTIVE_LOW = 1'b1;
    localparam logic [7:0] Y_IDLE_TB  = 8'hFF;
`else
    localparam bit         ACTIVE_LOW = 1'b0;
    localparam logic [7:0] Y_IDLE_TB  = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, in_valid;
    logic [2:0] code;

    logic       rdy0, rdy1, yv0, yv1, done0, done1;
    logic [7:0] y0, y1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    three_eight_decoder_sequencer #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy0),
        .code(code), .y(y0), .y_valid(yv0), .done(done0)
    );

    three_eight_decoder_sequencer #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy1),
        .code(code), .y(y1), .y_valid(yv1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] line_of(input logic [2:0] c);
        logic [7:0] hot;
        hot = 8'd1 << c;
        return ACTIVE_LOW ? ~hot : hot;
    endfunction

    // Model: time since accept decides everything; busy for P+G cycles.
    int         p_len [2];
    int         g_len [2];
    bit         m_act [2];
    int         m_t   [2];
    logic [2:0] m_code[2];
    bit         m_done[2];

    initial begin
        p_len[0] = 4; g_len[0] = 1;
        p_len[1] = 1; g_len[1] = 0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_code[i] = 3'd0; m_done[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (!rst_n || !en) begin
                m_act[i] = 1'b0;
                m_t[i]   = 0;
            end else if (m_act[i]) begin
                m_t[i]++;
                if (m_t[i] == p_len[i]) m_done[i] = 1'b1;
                if (m_t[i] >= p_len[i] + g_len[i]) m_act[i] = 1'b0;
            end else if (in_valid) begin
                m_act[i]  = 1'b1;
                m_t[i]    = 0;
                m_code[i] = code;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            bit         e_yv;
            logic [7:0] e_y;
            bit         e_rdy;
            e_yv  = m_act[i] && (m_t[i] < p_len[i]);
            e_y   = e_yv ? line_of(m_code[i]) : Y_IDLE_TB;
            e_rdy = en && rst_n && !m_act[i];
            if (i == 0) begin
                chk("model_y0", {24'd0, y0}, {24'd0, e_y});
                chk("model_yv0", {31'd0, yv0}, {31'd0, e_yv});
                chk("model_done0", {31'd0, done0}, {31'd0, m_done[0]});
                chk("model_rdy0", {31'd0, rdy0}, {31'd0, e_rdy});
            end else begin
                chk("model_y1", {24'd0, y1}, {24'd0, e_y});
                chk("model_yv1", {31'd0, yv1}, {31'd0, e_yv});
                chk("model_done1", {31'd0, done1}, {31'd0, m_done[1]});
                chk("model_rdy1", {31'd0, rdy1}, {31'd0, e_rdy});
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic wait_ready(input int inst);
        int n;
        n = 0;
        while (((inst == 0) ? rdy0 : rdy1) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] sweep_exp [8];
    int         last_acc, this_acc;

    initial begin
        sweep_exp[0] = 8'h01; sweep_exp[1] = 8'h02; sweep_exp[2] = 8'h04; sweep_exp[3] = 8'h08;
        sweep_exp[4] = 8'h10; sweep_exp[5] = 8'h20; sweep_exp[6] = 8'h40; sweep_exp[7] = 8'h80;
        for (int i = 0; i < 8; i++) if (ACTIVE_LOW) sweep_exp[i] = ~sweep_exp[i];

        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; code = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        @(negedge clk);
        chk("reset_y", {24'd0, y0}, {24'd0, Y_IDLE_TB});
        chk("reset_yv", {31'd0, yv0}, 32'd0);
        chk("reset_done", {31'd0, done0}, 32'd0);
        chk("reset_rdy", {31'd0, rdy0}, 32'd1);

        // Sweep all codes back to back on the 4/1 instance.
        last_acc = -1;
        for (int c = 0; c < 8; c++) begin
            code = 3'(c); in_valid = 1'b1;
            wait_ready(0);
            @(negedge clk);
            this_acc = cyc;
            in_valid = 1'b0;
            chk("sweep_y", {24'd0, y0}, {24'd0, sweep_exp[c]});
            if (last_acc >= 0) chk("sweep_spacing", this_acc - last_acc, 32'd6);
            last_acc = this_acc;
        end

        // Mid-pulse code/valid changes are ignored.
        code = 3'd3; in_valid = 1'b1;
        wait_ready(0);
        @(negedge clk);
        code = 3'd6;
        for (int k = 0; k < 4; k++) begin
            chk("hold_y", {24'd0, y0}, {24'd0, sweep_exp[3]});
            @(negedge clk);
        end
        wait_ready(0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("after_hold_y", {24'd0, y0}, {24'd0, sweep_exp[6]});

        // Abort in the second pulse cycle.
        code = 3'd5; in_valid = 1'b1;
        wait_ready(0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_y", {24'd0, y0}, {24'd0, Y_IDLE_TB});
        chk("abort_yv", {31'd0, yv0}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("abort_rdy", {31'd0, rdy0}, 32'd0);
            chk("abort_done", {31'd0, done0}, 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("abort_rdy_back", {31'd0, rdy0}, 32'd1);

        // PULSE_LEN=1, GAP_LEN=0 instance: codes 2 then 7 with valid held.
        repeat (8) @(negedge clk);
        code = 3'd2; in_valid = 1'b1;
        wait_ready(1);
        @(negedge clk);
        chk("edge_y2", {24'd0, y1}, {24'd0, sweep_exp[2]});
        code = 3'd7;
        @(negedge clk);
        chk("edge_idle_y", {24'd0, y1}, {24'd0, Y_IDLE_TB});
        chk("edge_done_a", {31'd0, done1}, 32'd1);
        @(negedge clk);
        chk("edge_y7", {24'd0, y1}, {24'd0, sweep_exp[7]});
        in_valid = 1'b0;
        @(negedge clk);
        chk("edge_done_b", {31'd0, done1}, 32'd1);

        // Asynchronous reset in the middle of a pulse.
        repeat (8) @(negedge clk);
        code = 3'd4; in_valid = 1'b1;
        wait_ready(0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_y", {24'd0, y0}, {24'd0, Y_IDLE_TB});
        chk("async_yv", {31'd0, yv0}, 32'd0);
        chk("async_rdy", {31'd0, rdy0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        code = 3'd0; in_valid = 1'b1;
        wait_ready(0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("post_reset_y", {24'd0, y0}, {24'd0, ACTIVE_LOW ? 8'hFE : 8'h01});
            @(negedge clk);
        end

        // Random traffic checked by the model every cycle.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 15) != 0);
            in_valid = $urandom_range(0, 1) == 1;
            code     = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 79) == 0) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
